// File: rtl/udp_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one byte-wide AXI-Stream MAC TX port between NUM_SRC sources.
// Optional macro UDP_TX_ARB_ACK_PRIO_EN: source 0 (ACK) wins every idle arbitration it requests.
module udp_tx_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*NUM_SRC-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]   s_tvalid,
    input  logic [NUM_SRC-1:0]   s_tlast,
    output logic [NUM_SRC-1:0]   s_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [NUM_SRC-1:0]   o_grant,
    output logic                 o_busy,
    output logic [NUM_SRC-1:0]   o_frame_done
);

    localparam int PW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] grant, grant_nxt;
    logic [PW-1:0]      gidx, gidx_nxt;
    logic [PW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [3:0]         gap_cnt, gap_cnt_nxt;

    logic [NUM_SRC-1:0] req;
    logic               win_vld;
    logic [PW-1:0]      win_idx;
    logic [PW:0]        idx;
    logic               beat, last_beat;

    // Combinational datapath; a zero grant forces every output to 0.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                m_tdata  = m_tdata | s_tdata[8*i +: 8];
                m_tvalid = m_tvalid | s_tvalid[i];
                m_tlast  = m_tlast | s_tlast[i];
            end
        end
    end

    assign s_tready     = grant & {NUM_SRC{m_tready}};
    assign beat         = m_tvalid & m_tready;
    assign last_beat    = beat & m_tlast;
    assign o_frame_done = last_beat ? grant : '0;
    assign o_grant      = grant;
    assign o_busy       = (state == S_XFER);

    // Round-robin search from rr_ptr, wrapping at NUM_SRC.
    always_comb begin
        req = s_tvalid;
`ifdef UDP_TX_ARB_ACK_PRIO_EN
        req[0] = 1'b0;
`endif
        win_vld = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_SRC))
                idx = idx - (PW+1)'(NUM_SRC);
            if (!win_vld && req[idx[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = idx[PW-1:0];
            end
        end
`ifdef UDP_TX_ARB_ACK_PRIO_EN
        if (s_tvalid[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
        end
`endif
    end

    // Arbitration and the gap count do not wait for m_tready: the MAC may hold
    // ready low until it sees valid. The idle arbitration cycle follows the gap.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        gidx_nxt    = gidx;
        rr_ptr_nxt  = rr_ptr;
        gap_cnt_nxt = gap_cnt;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_nxt = S_XFER;
                    grant_nxt = NUM_SRC'(1) << win_idx;
                    gidx_nxt  = win_idx;
                end
            end
            S_XFER: begin
                if (last_beat) begin
                    grant_nxt   = '0;
                    gap_cnt_nxt = '0;
                    state_nxt   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
`ifdef UDP_TX_ARB_ACK_PRIO_EN
                    if (gidx != '0)
`endif
                        rr_ptr_nxt = (gidx == PW'(NUM_SRC-1)) ? '0 : gidx + PW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'(GAP_CYCLES-1)) begin
                    state_nxt   = S_IDLE;
                    gap_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            grant   <= '0;
            gidx    <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            gidx    <= gidx_nxt;
            rr_ptr  <= rr_ptr_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(o_grant));
    a_busy_grant:   assert property (@(posedge clk) disable iff (rst) o_busy == (o_grant != '0));

endmodule
